router_pkt_tx: RTL and testbench

Packet source that sits directly upstream of the 1x3 router and drives its `din` / `pkt_valid` input port. It accepts a command (destination address, payload length) and a byte stream of payload, buffers the whole payload internally, then serialises header, payload and computed parity onto the router input. Serialisation stalls whenever the router raises `busy`. Router-side `err` is captured into a per-packet status flag.

---
 rtl/router_pkt_tx.sv | 206 ++++++++++++++++++++
 tb/tb_router_pkt_tx.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: packet source feeding the 1x3 router input port.
//
// Accepts a command (destination addr, payload len), buffers len payload bytes, then
// serialises header {len, addr}, the payload and an XOR parity byte onto din/pkt_valid.
// Serialisation stalls while the router holds busy. Router err raises the sticky err_seen.
//
// Ports:
//   clk, resetn            clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake; cmd_addr (0..2), cmd_len (1..63)
//   cmd_err                one-cycle pulse when a command is rejected (addr 3 or len 0)
//   s_data/s_valid/s_ready payload byte stream, consumed only while loading
//   busy, err              router stall and router parity error
//   din, pkt_valid         byte stream to the router (pkt_valid low on the parity byte)
//   done                   one-cycle pulse after the parity byte is consumed
//   err_seen               sticky router error flag, cleared by the next accepted command
//   parity_inj             corrupt parity of the next packet
//
// Build option: define ROUTER_PKT_TX_PARITY_INJ_EN to enable parity_inj; otherwise it is
// ignored and parity is always correct.

module router_pkt_tx #(
   parameter int unsigned MAX_LEN = 63
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_addr,
   input  logic [5:0] cmd_len,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   output logic       s_ready,
   input  logic       busy,
   input  logic       err,
   output logic [7:0] din,
   output logic       pkt_valid,
   output logic       done,
   output logic       cmd_err,
   output logic       err_seen,
   input  logic       parity_inj
);

   typedef enum logic [2:0] {StIdle, StLoad, StHdr, StPld, StPar, StDone} state_e;

   state_e     state_q, state_d;
   logic [1:0] addr_q, addr_d;
   logic [5:0] len_q, len_d;
   logic [5:0] cnt_q, cnt_d;
   logic [7:0] parity_q, parity_d;
   logic [7:0] din_q, din_d;
   logic       pkt_valid_q, pkt_valid_d;
   logic       done_q, done_d;
   logic       cmd_err_q, cmd_err_d;
   logic       err_seen_q, err_seen_d;
   logic       cmd_ready_q, cmd_ready_d;
   logic [7:0] par_mask;
   logic [7:0] mem_q [MAX_LEN];

   logic cmd_fire, cmd_bad, cmd_accept, s_fire;

   // cmd_ready is registered so it stays low for the whole reset and the first cycle after.
   assign cmd_fire   = cmd_valid && cmd_ready_q;
   assign cmd_bad    = (cmd_addr == 2'd3) || (cmd_len == 6'd0);
   assign cmd_accept = cmd_fire && !cmd_bad;
   assign s_fire     = s_valid && (state_q == StLoad);

`ifdef ROUTER_PKT_TX_PARITY_INJ_EN
   logic inj_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         inj_q <= 1'b0;
      end else if (cmd_accept) begin
         inj_q <= parity_inj;
      end
   end

   assign par_mask = {8{inj_q}};
`else
   logic unused_parity_inj;
   assign unused_parity_inj = parity_inj;
   assign par_mask          = 8'h00;
`endif

   // Payload buffer carries no reset: every byte is rewritten before it is read.
   always_ff @(posedge clk) begin
      if (s_fire) begin
         mem_q[cnt_q] <= s_data;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= StIdle;
         addr_q      <= 2'd0;
         len_q       <= 6'd0;
         cnt_q       <= 6'd0;
         parity_q    <= 8'h00;
         din_q       <= 8'h00;
         pkt_valid_q <= 1'b0;
         done_q      <= 1'b0;
         cmd_err_q   <= 1'b0;
         err_seen_q  <= 1'b0;
         cmd_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         parity_q    <= parity_d;
         din_q       <= din_d;
         pkt_valid_q <= pkt_valid_d;
         done_q      <= done_d;
         cmd_err_q   <= cmd_err_d;
         err_seen_q  <= err_seen_d;
         cmd_ready_q <= cmd_ready_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      parity_d   = parity_q;
      cmd_err_d  = 1'b0;
      err_seen_d = err_seen_q | (err && (state_q != StIdle));

      unique case (state_q)
         StIdle: begin
            if (cmd_fire) begin
               if (cmd_bad) begin
                  cmd_err_d = 1'b1;
               end else begin
                  addr_d     = cmd_addr;
                  len_d      = cmd_len;
                  cnt_d      = 6'd0;
                  err_seen_d = 1'b0;
                  state_d    = StLoad;
               end
            end
         end
         StLoad: begin
            if (s_valid) begin
               if (cnt_q == len_q - 6'd1) begin
                  cnt_d    = 6'd0;
                  parity_d = {len_q, addr_q};
                  state_d  = StHdr;
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end
         end
         StHdr: begin
            if (!busy) begin
               state_d = StPld;
            end
         end
         StPld: begin
            if (!busy) begin
               parity_d = parity_q ^ mem_q[cnt_q];
               if (cnt_q == len_q - 6'd1) begin
                  state_d = StPar;
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end
         end
         StPar: begin
            if (!busy) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Registered outputs are decoded from next state so they line up with the state itself;
   // a stall keeps state and counter unchanged, which holds din/pkt_valid.
   always_comb begin
      cmd_ready_d = (state_d == StIdle);
      pkt_valid_d = (state_d == StHdr) || (state_d == StPld);
      done_d      = (state_d == StDone);
      din_d       = 8'h00;
      unique case (state_d)
         StHdr:   din_d = {len_d, addr_d};
         StPld:   din_d = mem_q[cnt_d];
         StPar:   din_d = parity_d ^ par_mask;
         default: din_d = 8'h00;
      endcase
   end

   assign cmd_ready = cmd_ready_q;
   assign s_ready   = (state_q == StLoad);
   assign din       = din_q;
   assign pkt_valid = pkt_valid_q;
   assign done      = done_q;
   assign cmd_err   = cmd_err_q;
   assign err_seen  = err_seen_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: the stimulus side queues the expected byte stream of
// every accepted packet; a negedge monitor compares din/pkt_valid/done as bytes are consumed.

module tb_router_pkt_tx;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_addr = 2'd0;
   logic [5:0] cmd_len = 6'd0;
   logic [7:0] s_data = 8'h00;
   logic       s_valid = 1'b0;
   logic       s_ready;
   logic       busy = 1'b0;
   logic       err = 1'b0;
   logic [7:0] din;
   logic       pkt_valid;
   logic       done;
   logic       cmd_err;
   logic       err_seen;
   logic       parity_inj = 1'b0;

   router_pkt_tx dut (
      .clk        (clk),
      .resetn     (resetn),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_addr   (cmd_addr),
      .cmd_len    (cmd_len),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .busy       (busy),
      .err        (err),
      .din        (din),
      .pkt_valid  (pkt_valid),
      .done       (done),
      .cmd_err    (cmd_err),
      .err_seen   (err_seen),
      .parity_inj (parity_inj)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       par;
      logic [7:0] b;
   } exp_t;

   exp_t       sb [$];
   logic [7:0] pl_q [$];
   int         checks = 0;
   int         errors = 0;
   bit         done_due = 1'b0;
   bit         busy_en = 1'b0;
   bit         exp_err_seen = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Random router back-pressure.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         busy = busy_en ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
   end

   // Monitor: a byte is consumed at the next rising edge when presented with busy low.
   initial begin
      forever begin
         @(negedge clk);
         if (!resetn) begin
            done_due = 1'b0;
            continue;
         end
         check("done pulse", done, done_due);
         done_due = 1'b0;
         if (pkt_valid) begin
            if (sb.size() == 0) begin
               check("pkt_valid with no packet pending", pkt_valid, 0);
            end else if (sb[0].par) begin
               check("pkt_valid on parity byte", pkt_valid, 0);
            end else begin
               check("din byte", din, sb[0].b);
               if (!busy) void'(sb.pop_front());
            end
         end else if (sb.size() != 0 && sb[0].par) begin
            check("parity byte", din, sb[0].b);
            if (!busy) begin
               void'(sb.pop_front());
               done_due = 1'b1;
            end
         end
      end
   end

   task automatic wait_cmd_ready();
      int n = 0;
      while (!cmd_ready && n < 300) begin
         tick();
         n++;
      end
      check("cmd_ready wait", cmd_ready, 1);
   endtask

   // Issue a command and feed its payload (pl_q, or random bytes if pl_q is empty).
   task automatic issue(input logic [1:0] a, input logic [5:0] l, input bit inj,
                        input bit gap, input bit err_in_load);
      logic [7:0] hdr, par;
      int         i, cyc, err_at;
      if (pl_q.size() == 0) begin
         for (int k = 0; k < int'(l); k++) pl_q.push_back(8'($urandom_range(0, 255)));
      end
      wait_cmd_ready();
      cmd_valid  = 1'b1;
      cmd_addr   = a;
      cmd_len    = l;
      parity_inj = inj;
      hdr = 8'(int'(l) * 4 + int'(a));
      par = hdr;
      sb.push_back('{par: 1'b0, b: hdr});
      for (int k = 0; k < int'(l); k++) begin
         sb.push_back('{par: 1'b0, b: pl_q[k]});
         par = par ^ pl_q[k];
      end
`ifdef ROUTER_PKT_TX_PARITY_INJ_EN
      if (inj) par = ~par;
`endif
      sb.push_back('{par: 1'b1, b: par});
      tick();
      cmd_valid    = 1'b0;
      parity_inj   = 1'($urandom);
      exp_err_seen = 1'b0;
      check("cmd_ready in load", cmd_ready, 0);
      check("s_ready in load", s_ready, 1);
      check("err_seen cleared on accept", err_seen, 0);
      i = 0;
      cyc = 0;
      err_at = $urandom_range(0, int'(l) - 1);
      while (i < int'(l) && cyc < 1000) begin
         s_valid = gap ? cyc[0] : 1'b1;
         s_data  = pl_q[i];
         err     = err_in_load && (cyc == err_at);
         if (err) exp_err_seen = 1'b1;
         tick();
         if (s_valid) i++;
         cyc++;
      end
      err     = 1'b0;
      s_valid = 1'($urandom);
      s_data  = 8'($urandom);
      check("load cycles", cyc, gap ? 2 * int'(l) : int'(l));
      check("header follows load", pkt_valid, 1);
      check("s_ready after load", s_ready, 0);
      check("err_seen after load", err_seen, exp_err_seen);
      pl_q.delete();
   endtask

   task automatic wait_done(input bit err_after);
      int n = 0;
      while (!done && n < 1000) begin
         s_valid = 1'($urandom);
         tick();
         n++;
      end
      check("done seen", done, 1);
      err = err_after;
      tick();
      err     = 1'b0;
      s_valid = 1'b0;
      if (err_after) exp_err_seen = 1'b1;
      check("err_seen after packet", err_seen, exp_err_seen);
      check("cmd_ready after done", cmd_ready, 1);
      check("done single cycle", done, 0);
      check("scoreboard drained", sb.size(), 0);
   endtask

   task automatic reject(input logic [1:0] a, input logic [5:0] l);
      wait_cmd_ready();
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_len   = l;
      tick();
      check("cmd_err pulse", cmd_err, 1);
      check("cmd_ready after reject", cmd_ready, 1);
      cmd_valid = 1'b0;
      tick();
      check("cmd_err cleared", cmd_err, 0);
      check("no packet after reject", pkt_valid, 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset cmd_ready", cmd_ready, 0);
      check("reset s_ready", s_ready, 0);
      check("reset din", din, 0);
      check("reset pkt_valid", pkt_valid, 0);
      check("reset done", done, 0);
      check("reset cmd_err", cmd_err, 0);
      check("reset err_seen", err_seen, 0);
      resetn = 1'b1;
      tick();
      check("cmd_ready after reset", cmd_ready, 1);

      // Directed packet, no stall.
      pl_q = '{8'h11, 8'h22, 8'h33, 8'h44};
      issue(2'd1, 6'd4, 1'b0, 1'b0, 1'b0);
      wait_done(1'b0);

      // Same packet under back-pressure.
      busy_en = 1'b1;
      pl_q = '{8'h11, 8'h22, 8'h33, 8'h44};
      issue(2'd1, 6'd4, 1'b0, 1'b0, 1'b0);
      wait_done(1'b0);

      // err in IDLE is ignored.
      err = 1'b1;
      tick();
      err = 1'b0;
      check("err ignored in idle", err_seen, 0);

      reject(2'd3, 6'd5);
      reject(2'd0, 6'd0);
      reject(2'd3, 6'd0);

      // Maximum length with a gapped payload stream.
      busy_en = 1'b0;
      issue(2'd2, 6'd63, 1'b0, 1'b1, 1'b0);
      wait_done(1'b1);

      // Parity injection request, single-byte packet.
      pl_q = '{8'h05};
      issue(2'd0, 6'd1, 1'b1, 1'b0, 1'b0);
      wait_done(1'b1);

      for (int p = 0; p < 25; p++) begin
         logic [5:0] l;
         busy_en = 1'($urandom);
         l = 6'($urandom_range(1, ($urandom_range(0, 3) == 0) ? 63 : 8));
         if ($urandom_range(0, 5) == 0) reject(2'd3, l);
         issue(2'($urandom_range(0, 2)), l, 1'($urandom), 1'($urandom), 1'($urandom));
         wait_done(1'($urandom));
      end

      // Reset in the middle of the payload.
      busy_en = 1'b0;
      issue(2'd2, 6'd10, 1'b0, 1'b0, 1'b0);
      repeat (3) tick();
      #1;
      resetn = 1'b0;
      #1;
      check("mid-packet reset pkt_valid", pkt_valid, 0);
      check("mid-packet reset din", din, 0);
      check("mid-packet reset cmd_ready", cmd_ready, 0);
      check("mid-packet reset err_seen", err_seen, 0);
      sb.delete();
      exp_err_seen = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
      tick();
      issue(2'd1, 6'd2, 1'b0, 1'b0, 1'b0);
      wait_done(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
